// File: rtl/of_pkg.sv
// Shared types for the operand-fetch controller: operand kinds, register
// names, size codes, controller states and the held-instruction payload.
package of_pkg;

    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 64;
    localparam int unsigned IDXW  = $clog2(NREGS);
    localparam int unsigned OPW   = 8;

    typedef enum logic [1:0] {
        REGISTER = 2'd0,
        MEMORY   = 2'd1,
        IMM      = 2'd2
    } operand_t;

    typedef enum logic [3:0] {
        RAX = 4'd0, RCX = 4'd1, RDX = 4'd2,  RBX = 4'd3,
        RSP = 4'd4, RBP = 4'd5, RSI = 4'd6,  RDI = 4'd7,
        R8  = 4'd8, R9  = 4'd9, R10 = 4'd10, R11 = 4'd11,
        R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15
    } regname_t;

    typedef enum logic [1:0] {
        SZ_8  = 2'b00,
        SZ_16 = 2'b01,
        SZ_32 = 2'b10,
        SZ_64 = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_CHECK = 3'd1,
        ST_MREQ  = 3'd2,
        ST_MWAIT = 3'd3,
        ST_ISSUE = 3'd4,
        ST_DRAIN = 3'd5
    } of_state_t;

    typedef struct packed {
        logic [OPW-1:0] op;
        operand_t       srcty;
        logic [AW-1:0]  srcval;
        logic [AW-1:0]  dstval;
        size_t          size;
        logic           nop;
        logic           wr_dst;
    } of_instr_t;

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set on issue, cleared on
// writeback (set wins on collision), with two combinational lookups.
// Optional OF_CTRL_WB_BYPASS_EN: a same-cycle writeback hides the bit.
module of_scoreboard
    import of_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_set_en,
    input  logic [IDXW-1:0] i_set_idx,
    input  logic            i_clr_en,
    input  logic [IDXW-1:0] i_clr_idx,
    input  logic [IDXW-1:0] i_rd0_idx,
    input  logic [IDXW-1:0] i_rd1_idx,
    output logic            o_pend0_c,
    output logic            o_pend1_c
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Next pending vector: clear first so a same-index set overrides it.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clr_en) begin
            w_pend_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_pend_nxt[i_set_idx] = 1'b1;
        end
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

`ifdef OF_CTRL_WB_BYPASS_EN
    assign o_pend0_c = r_pend[i_rd0_idx] && !(i_clr_en && (i_clr_idx == i_rd0_idx));
    assign o_pend1_c = r_pend[i_rd1_idx] && !(i_clr_en && (i_clr_idx == i_rd1_idx));
`else
    assign o_pend0_c = r_pend[i_rd0_idx];
    assign o_pend1_c = r_pend[i_rd1_idx];
`endif

endmodule

// File: rtl/of_ctrl.sv
// Operand-fetch controller: holds one decoded instruction, stalls it on
// RAW hazards, sequences a load for MEMORY sources and hands it to operand
// fetch. Optional OF_CTRL_WB_BYPASS_EN releases hazards one cycle earlier.
module of_ctrl
    import of_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [7:0]    dec_op,
    input  logic [1:0]    dec_srcty,
    input  logic [1:0]    dec_dstty,
    input  logic [63:0]   dec_srcval,
    input  logic [63:0]   dec_dstval,
    input  logic [1:0]    dec_size,
    input  logic          dec_nop,
    input  logic          dec_wr_dst,
    output logic          of_valid,
    input  logic          of_ready,
    output logic [7:0]    of_op,
    output logic [1:0]    of_srcty,
    output logic [63:0]   of_dstval,
    output logic [1:0]    of_size,
    output logic          of_nop,
    output logic [63:0]   of_srcval,
    output logic          mem_req,
    output logic [63:0]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [63:0]   mem_rdata,
    input  logic          wb_valid,
    input  logic [3:0]    wb_reg,
    input  logic          flush
);

    of_state_t     r_state;
    of_state_t     w_state_nxt;
    of_instr_t     r_instr;
    of_instr_t     w_dec_instr;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic          w_accept;
    logic          w_fire;
    logic          w_set_en;
    logic          w_pend_dst;
    logic          w_pend_src;
    logic          w_hazard;
    logic          w_unused_dstty;

    // The destination type never changes the hazard rule (dst is always read).
    assign w_unused_dstty = ^dec_dstty;

    // Handshakes; both are gated by flush so nothing moves while flushing.
    assign dec_ready = !flush && ((r_state == ST_EMPTY) ||
                                  ((r_state == ST_ISSUE) && of_ready));
    assign of_valid  = (r_state == ST_ISSUE) && !flush;
    assign w_accept  = dec_valid && dec_ready;
    assign w_fire    = of_valid && of_ready;
    assign w_set_en  = w_fire && r_instr.wr_dst && !r_instr.nop;

    // Destination is always read as oper1; source only matters for REGISTER.
    assign w_hazard = w_pend_dst || ((r_instr.srcty == REGISTER) && w_pend_src);

    of_scoreboard u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_set_en  (w_set_en),
        .i_set_idx (r_instr.dstval[IDXW-1:0]),
        .i_clr_en  (wb_valid),
        .i_clr_idx (wb_reg),
        .i_rd0_idx (r_instr.dstval[IDXW-1:0]),
        .i_rd1_idx (r_instr.srcval[IDXW-1:0]),
        .o_pend0_c (w_pend_dst),
        .o_pend1_c (w_pend_src)
    );

    // Pack the decode fields into the held-instruction payload.
    always_comb begin
        w_dec_instr        = '0;
        w_dec_instr.op     = dec_op;
        w_dec_instr.srcty  = operand_t'(dec_srcty);
        w_dec_instr.srcval = dec_srcval;
        w_dec_instr.dstval = dec_dstval;
        w_dec_instr.size   = size_t'(dec_size);
        w_dec_instr.nop    = dec_nop;
        w_dec_instr.wr_dst = dec_wr_dst;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (flush)            w_state_nxt = ST_EMPTY;
                else if (r_instr.nop) w_state_nxt = ST_ISSUE;
                else if (!w_hazard)   w_state_nxt = (r_instr.srcty == MEMORY) ? ST_MREQ : ST_ISSUE;
            end
            ST_MREQ: begin
                // A granted load must have its data drained before going idle.
                if (mem_gnt)    w_state_nxt = flush ? ST_DRAIN : ST_MWAIT;
                else if (flush) w_state_nxt = ST_EMPTY;
            end
            ST_MWAIT: begin
                if (mem_rvalid) w_state_nxt = flush ? ST_EMPTY : ST_ISSUE;
                else if (flush) w_state_nxt = ST_DRAIN;
            end
            ST_ISSUE: begin
                if (flush)         w_state_nxt = ST_EMPTY;
                else if (of_ready) w_state_nxt = w_accept ? ST_CHECK : ST_EMPTY;
            end
            ST_DRAIN: begin
                if (mem_rvalid) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held instruction; load data replaces the address once it returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= w_dec_instr;
        end else if ((r_state == ST_MWAIT) && mem_rvalid && !flush) begin
            r_instr.srcval <= mem_rdata;
        end
    end

    // Registered load request, high for exactly the MREQ cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_req <= (w_state_nxt == ST_MREQ);
            if ((r_state == ST_CHECK) && (w_state_nxt == ST_MREQ)) begin
                r_mem_addr <= r_instr.srcval;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign of_op     = r_instr.op;
    assign of_srcty  = r_instr.srcty;
    assign of_srcval = r_instr.srcval;
    assign of_dstval = r_instr.dstval;
    assign of_size   = r_instr.size;
    assign of_nop    = r_instr.nop;

endmodule

// File: tb/tb_of_ctrl.sv
// Bench for of_ctrl: directed scenarios followed by a randomized run checked
// against a transaction-level model (expected-instruction queue plus a
// pending-register array). Build with OF_CTRL_WB_BYPASS_EN to match that RTL.
module tb_of_ctrl;
    import of_pkg::*;

`ifdef OF_CTRL_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_op;
    logic [1:0]  dec_srcty;
    logic [1:0]  dec_dstty;
    logic [63:0] dec_srcval;
    logic [63:0] dec_dstval;
    logic [1:0]  dec_size;
    logic        dec_nop;
    logic        dec_wr_dst;
    logic        of_valid;
    logic        of_ready;
    logic [7:0]  of_op;
    logic [1:0]  of_srcty;
    logic [63:0] of_dstval;
    logic [1:0]  of_size;
    logic        of_nop;
    logic [63:0] of_srcval;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        flush;

    of_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_op     (dec_op),
        .dec_srcty  (dec_srcty),
        .dec_dstty  (dec_dstty),
        .dec_srcval (dec_srcval),
        .dec_dstval (dec_dstval),
        .dec_size   (dec_size),
        .dec_nop    (dec_nop),
        .dec_wr_dst (dec_wr_dst),
        .of_valid   (of_valid),
        .of_ready   (of_ready),
        .of_op      (of_op),
        .of_srcty   (of_srcty),
        .of_dstval  (of_dstval),
        .of_size    (of_size),
        .of_nop     (of_nop),
        .of_srcval  (of_srcval),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  srcty;
        logic [63:0] srcval;
        logic [63:0] addr;
        logic [63:0] dstval;
        logic [1:0]  size;
        logic        nop;
        logic        wr_dst;
    } rec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    rec_t        exp_q[$];
    rec_t        cand;
    rec_t        fire_rec;
    logic [15:0] m_pend;
    logic        offer;
    logic        load_busy;
    int          rv_cnt;
    logic [63:0] rv_data;
    logic        ev_acc, ev_fire, ev_wb, ev_gnt, ev_rv;
    logic [3:0]  ev_wb_reg;
    logic [3:0]  pick;
    logic        hz;
    int          last_fire;
    int          n_issued;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put_instr(input logic [7:0] op, input logic [1:0] ty,
                             input logic [63:0] sv, input logic [63:0] dv,
                             input logic wr, input logic nop);
        dec_valid  = 1'b1;
        dec_op     = op;
        dec_srcty  = ty;
        dec_dstty  = REGISTER;
        dec_srcval = sv;
        dec_dstval = dv;
        dec_size   = 2'b11;
        dec_nop    = nop;
        dec_wr_dst = wr;
    endtask

    initial begin
        reset_n = 1'b0; dec_valid = 1'b0; dec_op = '0; dec_srcty = '0; dec_dstty = '0;
        dec_srcval = '0; dec_dstval = '0; dec_size = '0; dec_nop = 1'b0; dec_wr_dst = 1'b0;
        of_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_of_valid", 64'(of_valid), 64'd0);
        chk("rst_mem_req",  64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_srcval",   of_srcval, 64'd0);
        chk("rst_pend",     64'(dut.u_sb.r_pend), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("rst_dec_ready", 64'(dec_ready), 64'd1);
        chk("rst_state",     64'(dut.r_state), 64'(ST_EMPTY));

        // RAW hazard: ADD RAX,RCX then ADD RBX,RAX
        of_ready = 1'b1;
        put_instr(8'h01, REGISTER, 64'd1, 64'd0, 1'b1, 1'b0);
        settle();
        chk("raw_dec_ready", 64'(dec_ready), 64'd1);
        tick();
        put_instr(8'h01, REGISTER, 64'd0, 64'd3, 1'b0, 1'b0);
        settle();
        chk("raw_check_valid", 64'(of_valid), 64'd0);
        chk("raw_check_ready", 64'(dec_ready), 64'd0);
        tick();
        chk("raw_issue_valid", 64'(of_valid), 64'd1);
        chk("raw_issue_dst",   of_dstval, 64'd0);
        chk("raw_issue_src",   of_srcval, 64'd1);
        tick();
        dec_valid = 1'b0;
        settle();
        chk("raw_pend0_set", 64'(dut.u_sb.r_pend[0]), 64'd1);
        chk("raw_state",     64'(dut.r_state), 64'(ST_CHECK));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("raw_stall_valid", 64'(of_valid), 64'd0);
        end
        wb_valid = 1'b1; wb_reg = 4'd0;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("raw_pend0_clr",  64'(dut.u_sb.r_pend[0]), 64'd0);
        chk("raw_release_w1", 64'(of_valid), 64'(BYP));
        tick();
        chk("raw_release_w2", 64'(of_valid), 64'(!BYP));
        chk("raw_second_dst", of_dstval, 64'd3);
        tick();
        chk("raw_done_valid", 64'(of_valid), 64'd0);
        chk("raw_done_state", 64'(dut.r_state), 64'(ST_EMPTY));

        // Set wins: issue R8 with wr_dst while R8 is written back
        put_instr(8'h05, IMM, 64'h77, 64'd8, 1'b1, 1'b0);
        tick();
        dec_valid = 1'b0;
        tick();
        chk("setwin_valid", 64'(of_valid), 64'd1);
        wb_valid = 1'b1; wb_reg = 4'd8;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("setwin_pend", 64'(dut.u_sb.r_pend), 64'h0100);

        // Memory source with delayed grant and data
        put_instr(8'h8B, MEMORY, 64'h1000, 64'd5, 1'b0, 1'b0);
        tick();
        dec_valid = 1'b0;
        settle();
        chk("mem_req_check", 64'(mem_req), 64'd0);
        tick();
        chk("mem_req_1",  64'(mem_req), 64'd1);
        chk("mem_addr_1", mem_addr, 64'h1000);
        tick();
        chk("mem_req_2",  64'(mem_req), 64'd1);
        chk("mem_addr_2", mem_addr, 64'h1000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("mem_req_drop", 64'(mem_req), 64'd0);
        chk("mem_wait_valid", 64'(of_valid), 64'd0);
        tick();
        chk("mem_wait_valid2", 64'(of_valid), 64'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("mem_issue_valid", 64'(of_valid), 64'd1);
        chk("mem_srcval", of_srcval, 64'hDEADBEEF);
        chk("mem_srcty",  64'(of_srcty), 64'(MEMORY));
        tick();

        // Flush while waiting for load data
        put_instr(8'h8B, MEMORY, 64'h2000, 64'd2, 1'b1, 1'b0);
        tick();
        dec_valid = 1'b0;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1;
        settle();
        chk("flush_valid", 64'(of_valid), 64'd0);
        chk("flush_ready", 64'(dec_ready), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("flush_drain", 64'(dut.r_state), 64'(ST_DRAIN));
        chk("flush_drain_valid", 64'(of_valid), 64'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'h1111;
        settle();
        chk("flush_rv_valid", 64'(of_valid), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("flush_empty", 64'(dut.r_state), 64'(ST_EMPTY));
        chk("flush_after_valid", 64'(of_valid), 64'd0);
        chk("flush_pend", 64'(dut.u_sb.r_pend), 64'h0100);

        // Backpressure in ISSUE, then back-to-back accept
        of_ready = 1'b0;
        put_instr(8'h33, IMM, 64'h1234_5678_9ABC_DEF0, 64'd4, 1'b0, 1'b0);
        tick();
        put_instr(8'h44, IMM, 64'h55, 64'd6, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  64'(of_valid), 64'd1);
            chk("bp_ready",  64'(dec_ready), 64'd0);
            chk("bp_op",     64'(of_op), 64'h33);
            chk("bp_srcval", of_srcval, 64'h1234_5678_9ABC_DEF0);
            tick();
        end
        of_ready = 1'b1;
        settle();
        chk("bp_release_ready", 64'(dec_ready), 64'd1);
        tick();
        dec_valid = 1'b0;
        settle();
        chk("bp_b2b_state", 64'(dut.r_state), 64'(ST_CHECK));
        chk("bp_b2b_op",    64'(of_op), 64'h44);
        tick();
        tick();

        // Asynchronous reset in the middle of MREQ
        put_instr(8'h8B, MEMORY, 64'h3000, 64'd7, 1'b0, 1'b0);
        tick();
        dec_valid = 1'b0;
        tick();
        chk("arst_pre_req", 64'(mem_req), 64'd1);
        reset_n = 1'b0;
        settle();
        chk("arst_req",   64'(mem_req), 64'd0);
        chk("arst_valid", 64'(of_valid), 64'd0);
        chk("arst_pend",  64'(dut.u_sb.r_pend), 64'd0);
        tick();
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("arst_state", 64'(dut.r_state), 64'(ST_EMPTY));
        chk("arst_ready", 64'(dec_ready), 64'd1);

        // Randomized traffic against the transaction model
        m_pend = '0; offer = 1'b0; load_busy = 1'b0; rv_cnt = 0; rv_data = '0;
        ev_acc = 1'b0; ev_fire = 1'b0; ev_wb = 1'b0; ev_gnt = 1'b0; ev_rv = 1'b0;
        ev_wb_reg = '0; last_fire = 0; n_issued = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (ev_fire) void'(exp_q.pop_front());
            if (ev_acc) begin
                exp_q.push_back(cand);
                offer = 1'b0;
            end
            if (ev_rv) begin
                load_busy = 1'b0;
                if (exp_q.size() > 0) exp_q[0].srcval = rv_data;
            end
            if (ev_gnt) begin
                load_busy = 1'b1;
                rv_cnt = $urandom_range(1, 3);
            end
            if (ev_wb) m_pend[ev_wb_reg] = 1'b0;
            if (ev_fire && fire_rec.wr_dst && !fire_rec.nop) m_pend[fire_rec.dstval[3:0]] = 1'b1;

            if (!offer && ($urandom_range(0, 9) < 6)) begin
                cand.op     = 8'($urandom);
                cand.srcty  = 2'($urandom_range(0, 2));
                cand.srcval = {$urandom, $urandom};
                cand.addr   = cand.srcval;
                cand.dstval = {$urandom, $urandom};
                cand.size   = 2'($urandom);
                cand.nop    = ($urandom_range(0, 7) == 0);
                cand.wr_dst = ($urandom_range(0, 1) == 1);
                offer = 1'b1;
                dec_dstty = 2'($urandom_range(0, 2));
            end
            dec_valid  = offer;
            dec_op     = cand.op;
            dec_srcty  = cand.srcty;
            dec_srcval = cand.srcval;
            dec_dstval = cand.dstval;
            dec_size   = cand.size;
            dec_nop    = cand.nop;
            dec_wr_dst = cand.wr_dst;
            of_ready   = ($urandom_range(0, 3) != 0);

            wb_valid = 1'b0;
            if ((m_pend != 16'd0) && ($urandom_range(0, 2) == 0)) begin
                pick = 4'($urandom_range(0, 15));
                for (int k = 0; k < 16; k++) begin
                    if (!m_pend[pick]) pick = pick + 4'd1;
                end
                wb_valid = 1'b1;
                wb_reg   = pick;
            end else if ($urandom_range(0, 9) == 0) begin
                wb_valid = 1'b1;
                wb_reg   = 4'($urandom_range(0, 15));
            end

            mem_gnt    = mem_req && ($urandom_range(0, 1) == 1);
            mem_rvalid = 1'b0;
            if (load_busy) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    rv_data    = {$urandom, $urandom};
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                end
            end

            @(negedge clk);
            ev_acc    = dec_valid && dec_ready;
            ev_fire   = of_valid && of_ready;
            ev_wb     = wb_valid;
            ev_wb_reg = wb_reg;
            ev_gnt    = mem_req && mem_gnt;
            ev_rv     = mem_rvalid;

            chk("rnd_pend", 64'(dut.u_sb.r_pend), 64'(m_pend));
            if (mem_req) begin
                chk("rnd_req_inflight", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) chk("rnd_mem_addr", mem_addr, exp_q[0].addr);
            end
            if (ev_fire) begin
                chk("rnd_fire_inflight", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    fire_rec = exp_q[0];
                    chk("rnd_srcval", of_srcval, fire_rec.srcval);
                    chk("rnd_dstval", of_dstval, fire_rec.dstval);
                    chk("rnd_fields", 64'({of_op, of_srcty, of_size, of_nop}),
                        64'({fire_rec.op, fire_rec.srcty, fire_rec.size, fire_rec.nop}));
                    hz = !fire_rec.nop && (m_pend[fire_rec.dstval[3:0]] ||
                         ((fire_rec.srcty == REGISTER) && m_pend[fire_rec.srcval[3:0]]));
                    chk("rnd_hazard_clear", 64'(hz), 64'd0);
                end
                n_issued++;
                last_fire = cyc;
            end
            chk("rnd_progress", 64'((cyc - last_fire) <= 400), 64'd1);
            if ((cyc - last_fire) > 400) break;
        end
        chk("rnd_issued_min", 64'(n_issued >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
